// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into press events (plus hold/auto-repeat events when
// AUTO_REPEAT_EN is defined), arbitrated round-robin into a small valid/ready event FIFO.
module button_event_arbiter #(
  parameter int WIDTH         = 4,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int FIFO_DEPTH    = 4,
  parameter int ID_WIDTH      = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    buttons,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [ID_WIDTH-1:0] event_id,
  output logic                event_repeat,
  output logic [WIDTH-1:0]    pending,
  output logic                overflow,
  input  logic                overflow_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if (WIDTH < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("button_event_arbiter: illegal parameter set");
  end

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} btn_state_e;
  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] fire_rep;
  logic [WIDTH-1:0] flag_q, flag_d, flag_upd;
  logic             rep_mem [FIFO_DEPTH];
`else
  typedef enum logic {IDLE, HELD} btn_state_e;
`endif

  btn_state_e          state_q [WIDTH];
  btn_state_e          state_d [WIDTH];
  logic [WIDTH-1:0]    prev_q, blocked_q, rising, fire, coalesce, grant;
  logic [ID_WIDTH-1:0] rr_ptr, grant_id, id_mem [FIFO_DEPTH];
  logic                grant_found, push, pop, full, empty;
  logic [PTR_W:0]      wr_ptr, rd_ptr;

  function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base,
                                                    input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= WIDTH) sum = sum - WIDTH;
    return ID_WIDTH'(sum);
  endfunction

  // A button still high when reset releases stays blocked until it is seen low.
  assign rising = buttons & ~prev_q & ~blocked_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    fire = '0;
`ifdef AUTO_REPEAT_EN
    fire_rep = '0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
`ifdef AUTO_REPEAT_EN
      cnt_d[i] = '0;
`endif
      if (!buttons[i]) begin
        state_d[i] = IDLE;
      end else begin
        case (state_q[i])
          IDLE: if (rising[i]) begin
            state_d[i] = HELD;
            fire[i]    = 1'b1;
          end
`ifdef AUTO_REPEAT_EN
          HELD: if (cnt_q[i] == HOLD_LAST) begin
            state_d[i]  = REPEAT;
            fire[i]     = 1'b1;
            fire_rep[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          REPEAT: if (cnt_q[i] == REPEAT_LAST) begin
            fire[i]     = 1'b1;
            fire_rep[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
`else
          HELD: state_d[i] = HELD;
`endif
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = !empty && event_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int off = 0; off < WIDTH; off++) begin
      if (!grant_found && pending[rr_index(rr_ptr, off)]) begin
        grant_found = 1'b1;
        grant_id    = rr_index(rr_ptr, off);
      end
    end
    push  = grant_found && !full;
    grant = '0;
    if (push) grant[grant_id] = 1'b1;
  end

  // A fresh event on a bit being granted this cycle simply re-arms it.
  assign coalesce = fire & pending & ~grant;
`ifdef AUTO_REPEAT_EN
  assign flag_upd = fire & ~coalesce;
  assign flag_d   = (flag_q & ~flag_upd) | (fire_rep & flag_upd);
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= IDLE;
`ifdef AUTO_REPEAT_EN
        cnt_q[i] <= '0;
`endif
      end
`ifdef AUTO_REPEAT_EN
      flag_q <= '0;
`endif
      prev_q    <= '0;
      blocked_q <= buttons;
      pending   <= '0;
      overflow  <= 1'b0;
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
`ifdef AUTO_REPEAT_EN
        cnt_q[i] <= cnt_d[i];
`endif
      end
`ifdef AUTO_REPEAT_EN
      flag_q <= flag_d;
`endif
      prev_q    <= buttons;
      blocked_q <= blocked_q & buttons;
      pending   <= (pending & ~grant) | fire;
      if (|coalesce)        overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      if (push) begin
        rr_ptr <= rr_index(grant_id, 1);
        wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  // NOTE: the storage array is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr[PTR_W-1:0]] <= grant_id;
`ifdef AUTO_REPEAT_EN
      rep_mem[wr_ptr[PTR_W-1:0]] <= flag_q[grant_id];
`endif
    end
  end

  assign event_valid = !empty;
  assign event_id    = empty ? '0 : id_mem[rd_ptr[PTR_W-1:0]];
`ifdef AUTO_REPEAT_EN
  assign event_repeat = empty ? 1'b0 : rep_mem[rd_ptr[PTR_W-1:0]];
`else
  assign event_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: a per-cycle vector table plus hand-written
// sequences for auto-repeat, back-pressure/coalescing and reset mid-operation.
module tb_button_event_arbiter;

  localparam int W   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   buttons;
  logic           event_valid;
  logic           event_ready;
  logic [IDW-1:0] event_id;
  logic           event_repeat;
  logic [W-1:0]   pending;
  logic           overflow;
  logic           overflow_clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .WIDTH(W), .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .FIFO_DEPTH(4), .ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .rst(rst), .buttons(buttons),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_id(event_id), .event_repeat(event_repeat),
    .pending(pending), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  typedef struct {
    logic           rst;
    logic [W-1:0]   btn;
    logic           valid;
    logic [IDW-1:0] id;
    logic           rep;
    logic [W-1:0]   pend;
    logic           ovf;
  } vec_t;

  typedef struct {
    int cyc;
    int id;
    int rep;
  } ev_t;

  vec_t vecs[$];
  ev_t  got[$];
  ev_t  want[$];
  int   ids[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int i);
    buttons = W'(1) << i;
    tick();
    buttons = '0;
    tick();
  endtask

  function automatic vec_t mk(input logic r, input logic [W-1:0] b, input logic v,
                              input logic [IDW-1:0] id, input logic rp,
                              input logic [W-1:0] p, input logic o);
    vec_t t;
    t.rst = r; t.btn = b; t.valid = v; t.id = id; t.rep = rp; t.pend = p; t.ovf = o;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; buttons = '0; event_ready = 1'b1; overflow_clr = 1'b0;

    // Single press, simultaneous presses, round-robin order (rr_ptr ends at 0).
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0001, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1011, 0, 0, 0, 4'b1011, 0));
    vecs.push_back(mk(0, 4'b1011, 1, 0, 0, 4'b1010, 0));
    vecs.push_back(mk(0, 4'b1011, 1, 1, 0, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1011, 1, 3, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 4'b0011, 0));
    vecs.push_back(mk(0, 4'b0011, 1, 0, 0, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0));

    foreach (vecs[n]) begin
      rst     = vecs[n].rst;
      buttons = vecs[n].btn;
      tick();
      check($sformatf("vec%0d_valid", n), 32'(event_valid), 32'(vecs[n].valid));
      check($sformatf("vec%0d_pending", n), 32'(pending), 32'(vecs[n].pend));
      check($sformatf("vec%0d_overflow", n), 32'(overflow), 32'(vecs[n].ovf));
      if (vecs[n].valid || vecs[n].rst) begin
        check($sformatf("vec%0d_id", n), 32'(event_id), 32'(vecs[n].id));
        check($sformatf("vec%0d_repeat", n), 32'(event_repeat), 32'(vecs[n].rep));
      end
    end
    rst = 1'b0;

    // Hold button 2 for 30 sampled edges; events appear one edge after they fire.
    for (int c = 0; c < 45; c++) begin
      buttons = (c < 30) ? 4'b0100 : 4'b0000;
      tick();
      if (event_valid) got.push_back('{c, int'(event_id), int'(event_repeat)});
    end
    want.push_back('{1, 2, 0});
`ifdef AUTO_REPEAT_EN
    want.push_back('{11, 2, 1});
    want.push_back('{15, 2, 1});
    want.push_back('{19, 2, 1});
    want.push_back('{23, 2, 1});
    want.push_back('{27, 2, 1});
`endif
    check("hold_event_count", 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < got.size() && i < want.size(); i++) begin
      check($sformatf("hold_ev%0d_cycle", i), 32'(got[i].cyc), 32'(want[i].cyc));
      check($sformatf("hold_ev%0d_id", i), 32'(got[i].id), 32'(want[i].id));
      check($sformatf("hold_ev%0d_repeat", i), 32'(got[i].rep), 32'(want[i].rep));
    end

    // Back-pressure: fill FIFO with 0..3, then one pending and one coalesced press on 0.
    event_ready = 1'b0;
    for (int i = 0; i < W; i++) press(i);
    check("full_valid", 32'(event_valid), 32'(1));
    check("full_head_id", 32'(event_id), 32'(0));
    check("full_pending", 32'(pending), 32'(4'b0000));
    press(0);
    check("bp_pending", 32'(pending), 32'(4'b0001));
    check("bp_overflow", 32'(overflow), 32'(0));
    press(0);
    check("coalesce_pending", 32'(pending), 32'(4'b0001));
    check("coalesce_overflow", 32'(overflow), 32'(1));
    event_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (event_valid) ids.push_back(int'(event_id));
      tick();
    end
    check("drain_count", 32'(ids.size()), 32'(5));
    for (int i = 0; i < ids.size() && i < 5; i++)
      check($sformatf("drain%0d_id", i), 32'(ids[i]), 32'(i % W));
    check("drain_pending", 32'(pending), 32'(4'b0000));
    check("overflow_sticky", 32'(overflow), 32'(1));
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("overflow_cleared", 32'(overflow), 32'(0));

    // Coalescing in the same cycle as overflow_clr: set must win.
    event_ready = 1'b0;
    for (int i = 0; i < W; i++) press(i);
    press(1);
    buttons = 4'b0010;
    overflow_clr = 1'b1;
    tick();
    check("set_beats_clr", 32'(overflow), 32'(1));
    buttons = '0;
    overflow_clr = 1'b0;
    event_ready = 1'b1;
    ids.delete();
    for (int c = 0; c < 8; c++) begin
      if (event_valid) ids.push_back(int'(event_id));
      tick();
    end
    check("drain2_count", 32'(ids.size()), 32'(5));
    check("overflow_sticky2", 32'(overflow), 32'(1));

    // Reset mid-operation with two queued events and button 1 held through reset.
    event_ready = 1'b0;
    press(0);
    buttons = 4'b0010;
    tick();
    tick();
    check("pre_rst_valid", 32'(event_valid), 32'(1));
    check("pre_rst_pending", 32'(pending), 32'(4'b0000));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(event_valid), 32'(0));
    check("rst_id", 32'(event_id), 32'(0));
    check("rst_repeat", 32'(event_repeat), 32'(0));
    check("rst_pending", 32'(pending), 32'(4'b0000));
    check("rst_overflow", 32'(overflow), 32'(0));
    event_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("held_thru_rst%0d_pending", c), 32'(pending), 32'(4'b0000));
      check($sformatf("held_thru_rst%0d_valid", c), 32'(event_valid), 32'(0));
    end
    buttons = '0;
    tick();
    buttons = 4'b0010;
    tick();
    check("repress_pending", 32'(pending), 32'(4'b0010));
    tick();
    check("repress_valid", 32'(event_valid), 32'(1));
    check("repress_id", 32'(event_id), 32'(1));
    check("repress_repeat", 32'(event_repeat), 32'(0));
    buttons = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Sits downstream of the per-button debouncers. Turns debounced button levels into discrete press events, with optional auto-repeat for held buttons. Arbitrates simultaneous events round-robin into a small event FIFO, which the CPU-side MMIO logic drains with a valid/ready handshake. Lost events are flagged by a sticky overflow bit.

Parameters:
WIDTH, 4, number of debounced button inputs (>=2)
HOLD_CYCLES, 25000000, cycles a button must stay high before the first repeat event
REPEAT_CYCLES, 5000000, cycles between successive repeat events while held
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
ID_WIDTH, $clog2(WIDTH), width of event_id

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
buttons  input  WIDTH  debounced button levels, 1 = pressed
event_valid  output  1  FIFO head holds an event
event_ready  input  1  consumer accepts head this cycle
event_id  output  ID_WIDTH  button index of head event
event_repeat  output  1  head event is an auto-repeat (0 = initial press)
pending  output  WIDTH  per-button event detected, not yet queued
overflow  output  1  sticky: an event was coalesced/dropped
overflow_clr  input  1  clears overflow

Behaviour:
- Reset (sync, rst high at posedge) clears the following:
  - FIFO, so event_valid=0, event_id=0, event_repeat=0
  - pending=0, overflow=0
  - round-robin pointer to index 0
  - all button FSMs to IDLE and all hold counters to 0
  - the previous-sample register to 0
- Reset mid-operation discards queued events. A button held through reset produces no event until it is released and pressed again.
- Per-button FSM: IDLE, HELD, REPEAT.
  - IDLE→HELD on rising edge (buttons[i]=1, previous sample=0). Sets pending[i], with repeat flag 0. Counter cleared.
  - HELD: counter increments each cycle. When counter reaches HOLD_CYCLES-1: set pending[i] with repeat flag 1, clear counter, go to REPEAT.
  - REPEAT: at counter REPEAT_CYCLES-1, set pending[i] with repeat flag 1 and clear counter.
  - Any state→IDLE when buttons[i]=0. Counter cleared. pending[i] is not cleared by release.
- Coalescing: if an event fires for button i while pending[i] is already 1:
  - overflow is set.
  - pending stays 1.
  - The stored repeat flag keeps its older value (the oldest event wins).
- Arbiter:
  - Runs each cycle when the FIFO is not full at cycle start and pending != 0.
  - Grants the first set pending bit searching upward from rr_ptr, wrapping.
  - Pushes {id, repeat flag}, clears that pending bit, and sets rr_ptr = granted index + 1 (mod WIDTH).
  - At most one grant per cycle.
  - A pending bit being granted and a new event on the same button in the same cycle: the new event re-sets pending. No overflow.
- FIFO:
  - Head is registered.
  - Pop when event_valid && event_ready.
  - Full is evaluated before the pop, so a pop does not enable a push in the same cycle.
  - Simultaneous push and pop when neither full nor empty: occupancy unchanged.
  - event_ready while empty is ignored.
  - Pointers wrap mod FIFO_DEPTH, with an extra wrap bit for full/empty.
- Latency:
  - Rising edge sampled at edge k: pending high after k.
  - If uncontested and not full: pushed at k+1, event_valid high after k+1.
- Overflow:
  - Set by coalescing only; a full FIFO back-pressures into pending rather than dropping.
  - Set wins over overflow_clr in the same cycle.
- Counter widths: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)). No overflow beyond terminal counts.

Optional Feature:
AUTO_REPEAT_EN
- Defined: HELD/REPEAT counting and repeat events as above.
- Undefined: the FSM has only IDLE/HELD, there are no counters, only press events are produced, and event_repeat is tied to 0.

Test Plan (WIDTH=4, HOLD_CYCLES=10, REPEAT_CYCLES=4, FIFO_DEPTH=4, event_ready=1 unless stated):
1. Single press: buttons=0001 at cycle 5, released at 7 → pending[0]=1 after edge 5; event_valid=1 after edge 6 with id=0, repeat=0; exactly one event; overflow=0.
2. Simultaneous: buttons 0000→1011 in one cycle, rr_ptr=0 → events id 0,1,3 on three consecutive cycles, each repeat=0.
3. Round-robin fairness: after (2), release all, then press 0011 → next order is id 0 then 1 (rr_ptr=0 after granting 3).
4. Auto-repeat: hold button 2 for 30 cycles → one press, then repeat events at press+10, +14, +18, +22, +26 (event_repeat=1). Release stops them. With AUTO_REPEAT_EN undefined: only one event.
5. Backpressure and coalescing: event_ready=0; four presses on 0,1,2,3 fill the FIFO. A fifth press on 0 sets pending[0]; another press on 0 sets overflow=1. Raise event_ready → drain 0,1,2,3, then one more id 0. overflow stays 1 until overflow_clr.
6. Reset mid-operation: FIFO holding 2 events, button 1 held, rst for 1 cycle → event_valid=0, pending=0, overflow=0 next cycle. No event for button 1 until it is released and re-pressed.
